add_accum: RTL

Parametrised sequential successor to the team's 8-bit combinational adder. It sums a burst of `len` operands streamed in over a valid/ready handshake into a widened accumulator, in unsigned or signed mode, and flags overflow. It returns the result over a second valid/ready handshake. It sits in the datapath wherever a multi-operand sum is needed without chaining combinational adders.

---
 rtl/add_pkg.sv | 16 +
 rtl/add_core.sv | 45 ++++
 rtl/add_accum.sv | 111 +++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// Shared types for the add_accum burst accumulator: FSM state encoding and
// the default accumulator width for a given operand width.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Four guard bits cover a 16-operand burst without unsigned wrap.
    function automatic int def_accwidth(input int dw);
        return dw + 4;
    endfunction

endpackage

// File: rtl/add_core.sv
// Combinational add step: extends the operand, adds it to the accumulator and
// flags overflow. Saturating result when ADD_ACCUM_SAT_EN is defined.
module add_core
    import add_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ACCWIDTH  = 12
) (
    input  logic [ACCWIDTH-1:0]  acc_i,
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic                 signed_mode_i,
    output logic [ACCWIDTH-1:0]  sum_o,
    output logic                 ovf_o
);

    logic [ACCWIDTH-1:0] ext;
    logic [ACCWIDTH-1:0] raw;
    logic                carry;
    logic                sovf;

    always_comb begin
        ext                  = '0;
        ext[DATAWIDTH-1:0]   = a_i;
        for (int i = DATAWIDTH; i < ACCWIDTH; i++)
            ext[i] = signed_mode_i & a_i[DATAWIDTH-1];

        {carry, raw} = {1'b0, acc_i} + {1'b0, ext};
        // Signed overflow: like-signed inputs producing an opposite-signed result.
        sovf  = (acc_i[ACCWIDTH-1] == ext[ACCWIDTH-1]) &&
                (raw[ACCWIDTH-1] != acc_i[ACCWIDTH-1]);
        ovf_o = signed_mode_i ? sovf : carry;
        sum_o = raw;
`ifdef ADD_ACCUM_SAT_EN
        if (ovf_o) begin
            if (!signed_mode_i)
                sum_o = '1;
            else if (ext[ACCWIDTH-1])
                sum_o = {1'b1, {(ACCWIDTH-1){1'b0}}};
            else
                sum_o = {1'b0, {(ACCWIDTH-1){1'b1}}};
        end
`endif
    end

endmodule

// File: rtl/add_accum.sv
// Burst accumulator: sums len operands over a valid/ready stream and returns
// the result with a sticky overflow flag. Optional macro: ADD_ACCUM_SAT_EN.
module add_accum
    import add_pkg::*;
#(
    parameter  int DATAWIDTH = 8,
    parameter  int ACCWIDTH  = def_accwidth(DATAWIDTH),
    parameter  int MAXLEN    = 16,
    localparam int LENW      = $clog2(MAXLEN + 1)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [LENW-1:0]      len,
    input  logic                 signed_mode,
    input  logic [DATAWIDTH-1:0] a,
    input  logic                 a_valid,
    output logic                 a_ready,
    output logic [ACCWIDTH-1:0]  sum,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic                 ovf,
    output logic                 busy
);

    state_e              state_q, state_d;
    logic [ACCWIDTH-1:0] acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [LENW-1:0]     cnt_q, cnt_d;
    logic                smode_q, smode_d;

    logic                beat;
    logic [LENW-1:0]     len_clamped;
    logic [ACCWIDTH-1:0] core_sum;
    logic                core_ovf;

    assign beat        = (state_q == ACC) && a_valid;
    assign len_clamped = (len > LENW'(MAXLEN)) ? LENW'(MAXLEN) : len;

    add_core #(
        .DATAWIDTH (DATAWIDTH),
        .ACCWIDTH  (ACCWIDTH)
    ) u_core (
        .acc_i         (acc_q),
        .a_i           (a),
        .signed_mode_i (smode_q),
        .sum_o         (core_sum),
        .ovf_o         (core_ovf)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? DONE : ACC;
            ACC:     if (beat && cnt_q == LENW'(1)) state_d = DONE;
            DONE:    if (sum_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_ready   = (state_q == ACC);
        sum_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    assign sum = acc_q;
    assign ovf = ovf_q;

    always_comb begin
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        smode_d = smode_q;
        if (state_q == IDLE && start) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = len_clamped;
            smode_d = signed_mode;
        end else if (beat) begin
            cnt_d = cnt_q - LENW'(1);
            ovf_d = ovf_q | core_ovf;
`ifdef ADD_ACCUM_SAT_EN
            // Once saturated the value is frozen for the rest of the burst.
            if (!ovf_q) acc_d = core_sum;
`else
            acc_d = core_sum;
`endif
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            smode_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            smode_q <= smode_d;
        end
    end

endmodule
